sigma_bus_arb: RTL and testbench

Two-master, one-slave arbiter that shares the sigma SoC data bus between the CPU data port (master 0) and the UDM debug master (master 1). Sits between the two masters and the address decoder feeding RAM and CSRs. Grants one request per cycle, tracks the owner of each outstanding read, and routes the read response back to that owner. A response timeout keeps a missing slave from hanging the bus.

---
 rtl/sigma_bus_pkg.sv | 24 ++
 rtl/sigma_rr_pick2.sv | 25 ++
 rtl/sigma_bus_arb.sv | 154 +++++++++++++++
 tb/tb_sigma_bus_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_bus_pkg.sv
// Shared types and constants for the sigma SoC data-bus arbiter.
// Contents: bus request payload struct, arbiter FSM state enum, master ids
// and priority-mode encodings used by the pick logic.
package sigma_bus_pkg;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_RD_WAIT
  } arb_state_t;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_UDM = 1'b1;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/sigma_rr_pick2.sv
// Two-way winner selection for the sigma bus arbiter (purely combinational).
// Ports: req[1:0] active requests, last = master of the previous accepted
// transfer, mode (MODE_RR / MODE_FIXED), winner = selected master id.
module sigma_rr_pick2
  import sigma_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       mode,
  output logic       winner
);

  always_comb begin
    winner = ~last;
    case (req)
      2'b01:   winner = MASTER_CPU;
      2'b10:   winner = MASTER_UDM;
      // Tie: fixed mode favours the debug master, round-robin favours
      // whoever did not get the previous transfer.
      2'b11:   winner = (mode == MODE_FIXED) ? MASTER_UDM : ~last;
      default: winner = ~last;
    endcase
  end

endmodule

// File: rtl/sigma_bus_arb.sv
// Two-master (CPU = m0, UDM = m1) to one-slave arbiter for the sigma data bus.
// Ports: mN_* master request/ack/payload and registered read response,
// s_* slave-side mirror, timeout_cnt_o saturating count of response timeouts.
module sigma_bus_arb
  import sigma_bus_pkg::*;
#(
  parameter string       PRIORITY_MODE = "RR",
  parameter int          RESP_TIMEOUT  = 255,
  parameter logic [31:0] ERR_RDATA     = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  output logic        m0_ack_o,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  output logic        m1_ack_o,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        s_req_o,
  input  logic        s_ack_i,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_i,
  output logic [15:0] timeout_cnt_o
);

  localparam logic        MODE     = (PRIORITY_MODE == "FIXED") ? MODE_FIXED : MODE_RR;
  // Decision cycle for the timeout: the error response, registered one cycle
  // later, then lands RESP_TIMEOUT+1 cycles after the read accept.
  localparam logic [15:0] TMO_LAST = 16'(RESP_TIMEOUT - 1);

  arb_state_t  state;
  logic        owner;
  logic        rr_last;
  logic        locked;
  logic        lock_sel;
  logic [15:0] tmo_cnt;
  logic [15:0] tcnt;
  logic [1:0]  resp_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [1:0]  req_vec;
  logic        pick_win;
  logic        sel;
  logic        grant_req;
  logic        accept;
  bus_req_t    m0_pay;
  bus_req_t    m1_pay;
  bus_req_t    pay;

  assign req_vec = {m1_req_i, m0_req_i};
  assign m0_pay  = '{we: m0_we_i, addr: m0_addr_i, be: m0_be_i, wdata: m0_wdata_i};
  assign m1_pay  = '{we: m1_we_i, addr: m1_addr_i, be: m1_be_i, wdata: m1_wdata_i};

  sigma_rr_pick2 u_pick (
    .req    (req_vec),
    .last   (rr_last),
    .mode   (MODE),
    .winner (pick_win)
  );

  // A master already presented to the slave stays selected until it is
  // acked, so the payload never switches under a stalled slave.
  assign sel       = (locked && req_vec[lock_sel]) ? lock_sel : pick_win;
  assign pay       = (sel == MASTER_UDM) ? m1_pay : m0_pay;
  assign grant_req = !rst_i && (state == ARB_IDLE) && req_vec[sel];
  assign accept    = grant_req && s_ack_i;

  assign s_req_o   = grant_req;
  assign s_we_o    = rst_i ? 1'b0  : pay.we;
  assign s_addr_o  = rst_i ? 32'h0 : pay.addr;
  assign s_be_o    = rst_i ? 4'h0  : pay.be;
  assign s_wdata_o = rst_i ? 32'h0 : pay.wdata;
  assign m0_ack_o  = accept && (sel == MASTER_CPU);
  assign m1_ack_o  = accept && (sel == MASTER_UDM);

  assign m0_resp_o     = resp_q[0];
  assign m1_resp_o     = resp_q[1];
  assign m0_rdata_o    = resp_q[0] ? rdata_q : 32'h0;
  assign m1_rdata_o    = resp_q[1] ? rdata_q : 32'h0;
  assign m0_err_o      = resp_q[0] & err_q;
  assign m1_err_o      = resp_q[1] & err_q;
  assign timeout_cnt_o = tcnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ARB_IDLE;
      owner    <= MASTER_CPU;
      rr_last  <= MASTER_UDM;
      locked   <= 1'b0;
      lock_sel <= MASTER_CPU;
      tmo_cnt  <= 16'h0;
      tcnt     <= 16'h0;
      resp_q   <= 2'b00;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      resp_q <= 2'b00;
      err_q  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (accept) begin
            rr_last <= sel;
            locked  <= 1'b0;
            if (!pay.we) begin
              owner   <= sel;
              tmo_cnt <= 16'h0;
              state   <= ARB_RD_WAIT;
            end
          end else if (grant_req) begin
            locked   <= 1'b1;
            lock_sel <= sel;
          end else begin
            locked <= 1'b0;
          end
        end
        ARB_RD_WAIT: begin
          // A real response beats a timeout landing in the same cycle.
          if (s_resp_i) begin
            resp_q  <= (owner == MASTER_UDM) ? 2'b10 : 2'b01;
            rdata_q <= s_rdata_i;
            state   <= ARB_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            resp_q  <= (owner == MASTER_UDM) ? 2'b10 : 2'b01;
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
            if (tcnt != 16'hFFFF) tcnt <= tcnt + 16'h1;
            state   <= ARB_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'h1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_bus_arb.sv
// Self-checking bench for sigma_bus_arb: one round-robin instance with a short
// response timeout and one fixed-priority instance share the same stimulus.
// Directed table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_sigma_bus_arb;

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] W0 = 32'h1234_5678;
  localparam logic [31:0] W1 = 32'hCAFE_F00D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, m0_req, m0_we, m1_req, m1_we, s_ack, s_resp;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_be, m1_be;

  logic        r_m0_ack, r_m0_resp, r_m0_err, r_m1_ack, r_m1_resp, r_m1_err, r_s_req, r_s_we;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_s_addr, r_s_wdata;
  logic [3:0]  r_s_be;
  logic [15:0] r_tcnt;
  logic        f_m0_ack, f_m0_resp, f_m0_err, f_m1_ack, f_m1_resp, f_m1_err, f_s_req, f_s_we;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
  logic [3:0]  f_s_be;
  logic [15:0] f_tcnt;

  sigma_bus_arb #(.PRIORITY_MODE("RR"), .RESP_TIMEOUT(4), .ERR_RDATA(32'hDEADBEEF)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_ack_o(r_m0_ack), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_resp_o(r_m0_resp), .m0_rdata_o(r_m0_rdata),
    .m0_err_o(r_m0_err),
    .m1_req_i(m1_req), .m1_ack_o(r_m1_ack), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_resp_o(r_m1_resp), .m1_rdata_o(r_m1_rdata),
    .m1_err_o(r_m1_err),
    .s_req_o(r_s_req), .s_ack_i(s_ack), .s_we_o(r_s_we), .s_addr_o(r_s_addr), .s_be_o(r_s_be),
    .s_wdata_o(r_s_wdata), .s_resp_i(s_resp), .s_rdata_i(s_rdata), .timeout_cnt_o(r_tcnt)
  );

  sigma_bus_arb #(.PRIORITY_MODE("FIXED"), .RESP_TIMEOUT(255), .ERR_RDATA(32'hDEADBEEF)) u_fx (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_ack_o(f_m0_ack), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_resp_o(f_m0_resp), .m0_rdata_o(f_m0_rdata),
    .m0_err_o(f_m0_err),
    .m1_req_i(m1_req), .m1_ack_o(f_m1_ack), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_resp_o(f_m1_resp), .m1_rdata_o(f_m1_rdata),
    .m1_err_o(f_m1_err),
    .s_req_o(f_s_req), .s_ack_i(s_ack), .s_we_o(f_s_we), .s_addr_o(f_s_addr), .s_be_o(f_s_be),
    .s_wdata_o(f_s_wdata), .s_resp_i(s_resp), .s_rdata_i(s_rdata), .timeout_cnt_o(f_tcnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, r0, w0, r1, w1, ack, resp;
    logic [31:0] rdata;
    logic        e_sreq, e_swe;
    logic [31:0] e_addr;
    logic        e_ack0, e_ack1, e_resp0, e_resp1;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic do_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; s_resp = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Write, idle, reset, then RR reads where the slave answers one cycle
    // after each accept: grants must alternate m0, m1, m0, m1.
    //         rst r0 w0 r1 w1 ack rsp rdata          sreq swe addr ack0 ack1 rsp0 rsp1 rdata
    vecs[0]  = '{0, 1, 1, 0, 0, 1, 0, 32'h0,          1,   1,  A0,  1,   0,   0,   0,   32'h0};
    vecs[1]  = '{0, 0, 0, 0, 0, 1, 0, 32'h0,          0,   0,  0,   0,   0,   0,   0,   32'h0};
    vecs[2]  = '{1, 1, 0, 1, 0, 1, 0, 32'h0,          0,   0,  0,   0,   0,   0,   0,   32'h0};
    vecs[3]  = '{0, 1, 0, 1, 0, 1, 0, 32'h0,          1,   0,  A0,  1,   0,   0,   0,   32'h0};
    vecs[4]  = '{0, 1, 0, 1, 0, 1, 1, 32'h1111_0000,  0,   0,  0,   0,   0,   0,   0,   32'h0};
    vecs[5]  = '{0, 1, 0, 1, 0, 1, 0, 32'h0,          1,   0,  A1,  0,   1,   1,   0,   32'h1111_0000};
    vecs[6]  = '{0, 1, 0, 1, 0, 1, 1, 32'h2222_0001,  0,   0,  0,   0,   0,   0,   0,   32'h0};
    vecs[7]  = '{0, 1, 0, 1, 0, 1, 0, 32'h0,          1,   0,  A0,  1,   0,   0,   1,   32'h2222_0001};
    vecs[8]  = '{0, 1, 0, 1, 0, 1, 1, 32'h3333_0002,  0,   0,  0,   0,   0,   0,   0,   32'h0};
    vecs[9]  = '{0, 1, 0, 1, 0, 1, 0, 32'h0,          1,   0,  A1,  0,   1,   1,   0,   32'h3333_0002};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 1, 32'h4444_0003,  0,   0,  0,   0,   0,   0,   0,   32'h0};
    vecs[11] = '{0, 0, 0, 0, 0, 1, 0, 32'h0,          0,   0,  0,   0,   0,   0,   1,   32'h4444_0003};

    m0_addr = A0; m0_wdata = W0; m0_be = 4'hF; m0_we = 1'b0;
    m1_addr = A1; m1_wdata = W1; m1_be = 4'h3; m1_we = 1'b0;
    s_rdata = 32'h0;
    do_reset();
    #1;
    chk("rst_s_req", {31'h0, r_s_req}, 32'h0);
    chk("rst_resp", {30'h0, r_m1_resp, r_m0_resp}, 32'h0);
    chk("rst_tcnt", {16'h0, r_tcnt}, 32'h0);
    chk("rst_fx_tcnt", {16'h0, f_tcnt}, 32'h0);
    @(negedge clk);

    // ---- table-driven vectors on the round-robin instance ----
    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; m0_req = vecs[i].r0; m0_we = vecs[i].w0;
      m1_req = vecs[i].r1; m1_we = vecs[i].w1; s_ack = vecs[i].ack;
      s_resp = vecs[i].resp; s_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_s_req", i), {31'h0, r_s_req}, {31'h0, vecs[i].e_sreq});
      chk($sformatf("v%0d_m0_ack", i), {31'h0, r_m0_ack}, {31'h0, vecs[i].e_ack0});
      chk($sformatf("v%0d_m1_ack", i), {31'h0, r_m1_ack}, {31'h0, vecs[i].e_ack1});
      chk($sformatf("v%0d_m0_resp", i), {31'h0, r_m0_resp}, {31'h0, vecs[i].e_resp0});
      chk($sformatf("v%0d_m1_resp", i), {31'h0, r_m1_resp}, {31'h0, vecs[i].e_resp1});
      if (vecs[i].e_sreq) begin
        chk($sformatf("v%0d_s_we", i), {31'h0, r_s_we}, {31'h0, vecs[i].e_swe});
        chk($sformatf("v%0d_s_addr", i), r_s_addr, vecs[i].e_addr);
      end
      if (vecs[i].e_swe) begin
        chk($sformatf("v%0d_s_wdata", i), r_s_wdata, W0);
        chk($sformatf("v%0d_s_be", i), {28'h0, r_s_be}, 32'hF);
      end
      if (vecs[i].e_resp0) begin
        chk($sformatf("v%0d_m0_rdata", i), r_m0_rdata, vecs[i].e_rdata);
        chk($sformatf("v%0d_m0_err", i), {31'h0, r_m0_err}, 32'h0);
      end
      if (vecs[i].e_resp1) begin
        chk($sformatf("v%0d_m1_rdata", i), r_m1_rdata, vecs[i].e_rdata);
        chk($sformatf("v%0d_m1_err", i), {31'h0, r_m1_err}, 32'h0);
      end
      @(negedge clk);
    end

    // ---- fixed priority: m1 wins every tie until it drops req ----
    do_reset();
    m0_we = 1'b0; m1_we = 1'b0; m0_req = 1'b1; m1_req = 1'b1; s_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_resp = 1'b0;
      #1;
      chk($sformatf("fx%0d_m1_ack", k), {31'h0, f_m1_ack}, 32'h1);
      chk($sformatf("fx%0d_m0_ack", k), {31'h0, f_m0_ack}, 32'h0);
      chk($sformatf("fx%0d_addr", k), f_s_addr, A1);
      if (k > 0) begin
        chk($sformatf("fx%0d_m1_resp", k), {31'h0, f_m1_resp}, 32'h1);
        chk($sformatf("fx%0d_m1_rdata", k), f_m1_rdata, 32'hF000_0000 + 32'(k - 1));
        chk($sformatf("fx%0d_m0_resp", k), {31'h0, f_m0_resp}, 32'h0);
      end
      @(negedge clk);
      s_resp = 1'b1; s_rdata = 32'hF000_0000 + 32'(k);
      #1;
      chk($sformatf("fx%0d_wait_sreq", k), {31'h0, f_s_req}, 32'h0);
      @(negedge clk);
    end
    m1_req = 1'b0; s_resp = 1'b0;
    #1;
    chk("fx_last_m1_rdata", f_m1_rdata, 32'hF000_0002);
    chk("fx_m0_granted", {31'h0, f_m0_ack}, 32'h1);
    chk("fx_m0_addr", f_s_addr, A0);
    @(negedge clk);
    m0_req = 1'b0; s_resp = 1'b1; s_rdata = 32'h0BAD_0000;
    @(negedge clk);
    s_resp = 1'b0;
    #1;
    chk("fx_m0_resp", {31'h0, f_m0_resp}, 32'h1);
    chk("fx_m0_rdata", f_m0_rdata, 32'h0BAD_0000);
    chk("fx_m1_no_resp", {31'h0, f_m1_resp}, 32'h0);
    @(negedge clk);

    // ---- timeout on the round-robin instance (RESP_TIMEOUT = 4) ----
    do_reset();
    m1_we = 1'b0; m1_req = 1'b1; s_ack = 1'b1;
    #1;
    chk("to_accept", {31'h0, r_m1_ack}, 32'h1);
    @(negedge clk);
    m1_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("to_wait%0d", k), {31'h0, r_m1_resp}, 32'h0);
      @(negedge clk);
    end
    #1;
    chk("to_m1_resp", {31'h0, r_m1_resp}, 32'h1);
    chk("to_m1_err", {31'h0, r_m1_err}, 32'h1);
    chk("to_m1_rdata", r_m1_rdata, 32'hDEADBEEF);
    chk("to_m0_resp", {31'h0, r_m0_resp}, 32'h0);
    chk("to_tcnt", {16'h0, r_tcnt}, 32'h1);
    @(negedge clk);
    s_resp = 1'b1; s_rdata = 32'h5555_AAAA;
    @(negedge clk);
    s_resp = 1'b0;
    #1;
    chk("late_m1_resp", {31'h0, r_m1_resp}, 32'h0);
    chk("late_m0_resp", {31'h0, r_m0_resp}, 32'h0);
    chk("late_tcnt", {16'h0, r_tcnt}, 32'h1);
    @(negedge clk);
    // Response arriving in the timeout decision cycle: real data wins.
    m0_we = 1'b0; m0_req = 1'b1;
    #1;
    chk("race_accept", {31'h0, r_m0_ack}, 32'h1);
    @(negedge clk);
    m0_req = 1'b0;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    s_resp = 1'b1; s_rdata = 32'h600D_F00D;
    @(negedge clk);
    s_resp = 1'b0;
    #1;
    chk("race_resp", {31'h0, r_m0_resp}, 32'h1);
    chk("race_err", {31'h0, r_m0_err}, 32'h0);
    chk("race_rdata", r_m0_rdata, 32'h600D_F00D);
    chk("race_tcnt", {16'h0, r_tcnt}, 32'h1);
    @(negedge clk);

    // ---- stalled slave: m1 presented first stays selected until ack ----
    do_reset();
    m0_we = 1'b1; m1_we = 1'b1; s_ack = 1'b0; m1_req = 1'b1;
    #1;
    chk("stall0_sreq", {31'h0, r_s_req}, 32'h1);
    chk("stall0_addr", r_s_addr, A1);
    chk("stall0_ack", {30'h0, r_m1_ack, r_m0_ack}, 32'h0);
    @(negedge clk);
    m0_req = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      #1;
      chk($sformatf("stall%0d_addr", k), r_s_addr, A1);
      chk($sformatf("stall%0d_wdata", k), r_s_wdata, W1);
      chk($sformatf("stall%0d_ack", k), {30'h0, r_m1_ack, r_m0_ack}, 32'h0);
      @(negedge clk);
    end
    s_ack = 1'b1;
    #1;
    chk("stall_end_m1_ack", {31'h0, r_m1_ack}, 32'h1);
    chk("stall_end_m0_ack", {31'h0, r_m0_ack}, 32'h0);
    chk("stall_end_addr", r_s_addr, A1);
    @(negedge clk);
    #1;
    chk("after_stall_m0", {31'h0, r_m0_ack}, 32'h1);
    chk("after_stall_m1", {31'h0, r_m1_ack}, 32'h0);
    @(negedge clk);
    #1;
    chk("after_stall_m1_next", {31'h0, r_m1_ack}, 32'h1);
    @(negedge clk);

    // ---- reset while a read is outstanding ----
    do_reset();
    m0_we = 1'b0; m1_we = 1'b0; s_ack = 1'b1; m0_req = 1'b1;
    #1;
    chk("rw_accept", {31'h0, r_m0_ack}, 32'h1);
    @(negedge clk);
    m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b1; s_resp = 1'b1; s_rdata = 32'h7777_7777; m0_req = 1'b1; m1_req = 1'b1;
    #1;
    chk("rw_rst_sreq", {31'h0, r_s_req}, 32'h0);
    chk("rw_rst_ack", {30'h0, r_m1_ack, r_m0_ack}, 32'h0);
    chk("rw_rst_addr", r_s_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; s_resp = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rw_noresp%0d", k), {30'h0, r_m1_resp, r_m0_resp}, 32'h0);
      @(negedge clk);
    end
    m0_req = 1'b1; m1_req = 1'b1;
    #1;
    chk("rw_tie_m0", {31'h0, r_m0_ack}, 32'h1);
    chk("rw_tie_m1", {31'h0, r_m1_ack}, 32'h0);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
